output_deskew: RTL and testbench
================================

OUTPUT_DESKEW -- requirements
Module: output_deskew

Interface
REQ-001 The block SHALL have parameter ARRAY_SIZE, default 8, giving the number of array columns.
REQ-002 The block SHALL have parameter SUM_WIDTH, default 16, giving the width of one signed column sum.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of aligned rows buffered (power of 2, >=2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  high in the cycle column 0 of a result row is present on in_row.
REQ-007 in_row  input  ARRAY_SIZE*SUM_WIDTH  skewed bottom-row sums from the systolic array; column c at bits [c*SUM_WIDTH +: SUM_WIDTH].
REQ-008 out_valid  output  1  aligned row available on out_row.
REQ-009 out_ready  input  1  consumer accepts out_row this cycle.
REQ-010 out_row  output  ARRAY_SIZE*SUM_WIDTH  aligned row, same column packing as in_row.
REQ-011 count  output  clog2(FIFO_DEPTH)+1  number of rows held in the FIFO.
REQ-012 overflow  output  1  sticky flag: a row was dropped.

Function
REQ-013 Column c of a row SHALL be sampled from in_row in cycle T+c, where T is the cycle in which in_valid is high.
REQ-014 Column c SHALL pass through ARRAY_SIZE-1-c delay registers, so all columns are presented together at the FIFO write port in cycle T+ARRAY_SIZE-1.
REQ-015 in_valid SHALL pass through a delay line of ARRAY_SIZE-1 registers; its output is the FIFO write enable.
REQ-016 in_valid MAY be high in consecutive cycles; each such cycle starts an independent row, and rows SHALL NOT corrupt each other.
REQ-017 Sum values SHALL pass through unmodified: no sign extension, truncation or arithmetic.
REQ-018 The FIFO write SHALL occur on the clock edge ending cycle T+ARRAY_SIZE-1.
REQ-019 With the FIFO empty, out_valid SHALL rise in cycle T+ARRAY_SIZE, giving a latency of ARRAY_SIZE cycles.
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 out_row SHALL show the oldest stored row and SHALL remain stable while out_valid && !out_ready.
REQ-022 A pop SHALL occur on an edge where out_valid && out_ready.
REQ-023 A push and a pop on the same edge SHALL leave count unchanged, including when the FIFO is full.
REQ-024 A push with the FIFO full and no pop on the same edge SHALL drop the incoming row, leave FIFO contents and count unchanged, and set overflow.
REQ-025 overflow SHALL remain set until reset.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 out_ready with the FIFO empty SHALL have no effect.

Reset
REQ-028 While reset is low at a clock edge, the block SHALL clear the valid delay line, the FIFO pointers, count and overflow.
REQ-029 After reset, out_valid=0, count=0, overflow=0 and out_row=0.
REQ-030 Data delay registers need not be cleared; rows in flight when reset is asserted SHALL be discarded.
REQ-031 in_valid sampled while reset is low SHALL be ignored.

Verification (ARRAY_SIZE=4, SUM_WIDTH=8, FIFO_DEPTH=2)
REQ-032 Single row: in_valid at T=10, columns c0..c3 = 0x11, 0x22, 0x33, 0x44 presented at cycles 10..13 -> out_valid rises at cycle 14 with out_row=0x44332211; out_ready=1 -> count returns to 0 at cycle 15.
REQ-033 Back-to-back rows: in_valid at cycles 10 and 11 with rows A=0x04030201 and B=0x08070605 (each skewed as in REQ-013), out_ready=1 -> A out at cycle 14, B out at cycle 15, no mixed columns.
REQ-034 Signed passthrough: row of 0x80, 0xFF, 0x7F, 0x00 -> out_row=0x007FFF80, bit-exact.
REQ-035 Backpressure/overflow: three rows pushed with out_ready=0 -> count=2, overflow=1 after the third write edge; out_row holds the first row; later draining yields rows 1 and 2 only.
REQ-036 Full with simultaneous push and pop: FIFO full, out_ready=1 at the third row's write edge -> count stays 2, overflow stays 0, order preserved.
REQ-037 Reset mid-flight: reset low at cycle 12 of a row started at T=10 -> no out_valid afterwards; overflow=0 and count=0 after reset.

Source files
------------

// File: rtl/output_deskew_if.sv
// Handshake/bus bundle for output_deskew: skewed input rows in, aligned FIFO rows out.
interface output_deskew_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int SUM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int ROW_W = ARRAY_SIZE * SUM_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic             in_valid;
  logic [ROW_W-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [CW-1:0]    count;
  logic             overflow;

  modport slave (
    input  in_valid, in_row, out_ready,
    output out_valid, out_row, count, overflow
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  out_valid, out_row, count, overflow
  );
endinterface

// File: rtl/output_deskew.sv
// Realigns the diagonally skewed bottom-row sums of a systolic array into whole rows
// and buffers them in a small FIFO with a ready/valid output and a sticky overflow flag.
module output_deskew_lane #(
  parameter int W   = 16,
  parameter int DLY = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DLY-1:0][W-1:0] sr_q;

  always_ff @(posedge clk) begin
    sr_q[0] <= d_i;
    for (int i = 1; i < DLY; i++) sr_q[i] <= sr_q[i-1];
  end

  assign q_o = sr_q[DLY-1];
endmodule

module output_deskew #(
  parameter int ARRAY_SIZE = 8,
  parameter int SUM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  output_deskew_if.slave bus
);
  localparam int STAGES = ARRAY_SIZE - 1;
  localparam int ROW_W  = ARRAY_SIZE * SUM_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  logic [ARRAY_SIZE-1:0][SUM_WIDTH-1:0] in_cols, al_cols;
  assign in_cols = bus.in_row;

  // Column c arrives c cycles late, so it waits STAGES-c cycles; the last column is used live.
  for (genvar c = 0; c < STAGES; c++) begin : g_lane
    output_deskew_lane #(.W(SUM_WIDTH), .DLY(STAGES - c)) u_lane (
      .clk (clk),
      .d_i (in_cols[c]),
      .q_o (al_cols[c])
    );
  end
  assign al_cols[STAGES] = in_cols[STAGES];

  logic [STAGES:1] vld_pipe_q;
  logic            wr_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= bus.in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end
  assign wr_en = vld_pipe_q[STAGES];

  logic [FIFO_DEPTH-1:0][ROW_W-1:0] mem_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, do_push;

  always_comb begin
    full     = (cnt_q == CW'(FIFO_DEPTH));
    pop      = (cnt_q != '0) && bus.out_ready;
    // A full FIFO still accepts a row when the head leaves on the same edge.
    do_push  = wr_en && (!full || pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && pop) cnt_d = cnt_q - CW'(1);
    ovf_d    = ovf_q | (wr_en && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= al_cols;
  end

  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_row   = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = cnt_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_output_deskew.sv
// Directed and random stimulus for output_deskew, checked against a cycle-history row model.
module tb_output_deskew;
  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_deskew_if #(.ARRAY_SIZE(N), .SUM_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  output_deskew #(.ARRAY_SIZE(N), .SUM_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference: the last 8 cycles of sampled inputs, plus a queue of stored rows.
  logic [31:0] hrow [8];
  bit          hv   [8];
  bit          hr   [8];
  int          cyc = 0;
  logic [31:0] mq [$];
  bit          movf = 0;

  // Rows currently being presented, indexed by age in cycles.
  bit          act_v [4];
  logic [31:0] act_r [4];

  int passes = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update();
    int k = cyc % 8;
    hrow[k] = bus.in_row;
    hv[k]   = bus.in_valid;
    hr[k]   = reset;
    if (!reset) begin
      mq.delete();
      movf = 0;
    end else begin
      bit          pop  = (mq.size() != 0) && bus.out_ready;
      bit          push = 0;
      logic [31:0] row  = '0;
      // Row started at cyc-3 survives only if reset stayed high for its whole flight.
      if (cyc >= 3) begin
        push = hv[(cyc-3) % 8];
        for (int c = 0; c < N; c++) begin
          int j = (cyc - 3 + c) % 8;
          push = push & hr[j];
          row[c*W +: W] = hrow[j][c*W +: W];
        end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < D) mq.push_back(row);
        else movf = 1;
      end
    end
    cyc++;
  endtask

  task automatic tick(bit start, logic [31:0] row, bit rdy, bit rst_n);
    logic [31:0] d = $urandom;
    for (int a = 3; a > 0; a--) begin
      act_v[a] = act_v[a-1];
      act_r[a] = act_r[a-1];
    end
    act_v[0] = start;
    act_r[0] = row;
    for (int a = 0; a < N; a++)
      if (act_v[a]) d[a*W +: W] = act_r[a][a*W +: W];
    bus.in_row    = d;
    bus.in_valid  = start;
    bus.out_ready = rdy;
    reset         = rst_n;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("count",     32'(bus.count),     32'(mq.size()));
    chk("overflow",  32'(bus.overflow),  32'(movf));
    chk("out_row",   bus.out_row,        (mq.size() != 0) ? mq[0] : 32'h0);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) tick(0, 32'h0, rdy, 1'b1);
  endtask

  initial begin
    for (int a = 0; a < 4; a++) begin act_v[a] = 0; act_r[a] = '0; end
    for (int i = 0; i < 8; i++) begin hv[i] = 0; hr[i] = 0; hrow[i] = '0; end
    bus.in_valid = 0; bus.in_row = '0; bus.out_ready = 0; reset = 0;

    // Reset state
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 1, 0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.count),     32'h0);
    chk("rst_ovf",   32'(bus.overflow),  32'h0);
    chk("rst_row",   bus.out_row,        32'h0);

    // Single row: latency of N cycles, then drained
    tick(1, 32'h44332211, 1, 1);
    idle(2, 1);
    chk("single_early", 32'(bus.out_valid), 32'h0);
    idle(1, 1);
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_row",   bus.out_row,        32'h44332211);
    idle(1, 1);
    chk("single_drain", 32'(bus.count),     32'h0);

    // Back-to-back rows
    tick(1, 32'h04030201, 1, 1);
    tick(1, 32'h08070605, 1, 1);
    idle(2, 1);
    chk("b2b_A", bus.out_row, 32'h04030201);
    idle(1, 1);
    chk("b2b_B", bus.out_row, 32'h08070605);
    idle(1, 1);
    chk("b2b_empty", 32'(bus.out_valid), 32'h0);

    // Signed values pass bit-exact
    tick(1, 32'h007FFF80, 0, 1);
    idle(3, 0);
    chk("signed_row", bus.out_row, 32'h007FFF80);
    idle(1, 1);

    // Backpressure: third row dropped, overflow sticky
    tick(1, 32'hA1A2A3A4, 0, 1);
    tick(1, 32'hB1B2B3B4, 0, 1);
    tick(1, 32'hC1C2C3C4, 0, 1);
    idle(3, 0);
    chk("ovf_count", 32'(bus.count),    32'h2);
    chk("ovf_flag",  32'(bus.overflow), 32'h1);
    chk("ovf_head",  bus.out_row,       32'hA1A2A3A4);
    idle(1, 1);
    chk("ovf_second", bus.out_row, 32'hB1B2B3B4);
    idle(1, 1);
    chk("ovf_empty",  32'(bus.out_valid), 32'h0);
    chk("ovf_sticky", 32'(bus.overflow),  32'h1);
    tick(0, 32'h0, 0, 0);
    chk("ovf_cleared", 32'(bus.overflow), 32'h0);

    // Full FIFO with simultaneous push and pop
    tick(1, 32'h11121314, 0, 1);
    tick(1, 32'h21222324, 0, 1);
    tick(1, 32'h31323334, 0, 1);
    idle(2, 0);
    idle(1, 1);
    chk("full_pp_count", 32'(bus.count),    32'h2);
    chk("full_pp_ovf",   32'(bus.overflow), 32'h0);
    chk("full_pp_head",  bus.out_row,       32'h21222324);
    idle(1, 1);
    chk("full_pp_next",  bus.out_row,       32'h31323334);
    idle(1, 1);

    // Reset while a row is in flight
    tick(1, 32'h55667788, 0, 1);
    tick(0, 32'h0, 0, 1);
    tick(0, 32'h0, 0, 0);
    idle(6, 0);
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_count", 32'(bus.count),     32'h0);
    chk("midrst_ovf",   32'(bus.overflow),  32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      tick(bit'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) != 0));

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule
